mux_arb_nto1: RTL

- Parametrised N-input, 1-output multiplexer for the pipelined datapath.
- Each input channel has a valid/ready handshake.
- Two selection modes:
  - fixed: the channel is chosen by select_i.
  - round-robin: the channel is chosen by fair arbitration among valid inputs.
- The result is held in a one-entry registered output stage with valid/ready back-pressure, giving a one-cycle select-to-output latency.
- Used where several producers share one pipeline consumer: writeback port sharing, forwarding-source staging.

---
 rtl/mux_arb_nto1.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mux_arb_nto1.sv
// ============================================================================
// Module   : mux_arb_nto1
// Purpose  : N-to-1 valid/ready multiplexer with fixed or round-robin
//            selection feeding a one-entry registered output stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_arb_nto1 #(
  parameter int SIZE  = 32,
  parameter int NUM   = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mode_i,
  input  logic [SEL_W-1:0]      select_i,
  input  logic [NUM-1:0]        valid_i,
  input  logic [NUM*SIZE-1:0]   data_i,
  output logic [NUM-1:0]        ready_o,
  output logic                  valid_o,
  output logic [SIZE-1:0]       data_o,
  output logic [SEL_W-1:0]      grant_o,
  input  logic                  ready_i
);

  localparam logic [SEL_W:0] c_num = (SEL_W+1)'(NUM);

  logic                 r_valid;
  logic [SIZE-1:0]      r_data;
  logic [SEL_W-1:0]     r_grant;
  logic [SEL_W-1:0]     r_ptr;

  logic                 w_load_en;
  logic                 w_rr_found;
  logic [SEL_W-1:0]     w_rr_idx;
  logic [SEL_W:0]       w_pos;
  logic                 w_fx_ok;
  logic                 w_has_cand;
  logic [SEL_W-1:0]     w_cand;
  logic                 w_cand_valid;
  logic [SIZE-1:0]      w_cand_data;
  logic [NUM-1:0]       w_ready;
  logic                 w_accept;
  logic [SEL_W:0]       w_cand_inc;
  logic [SEL_W-1:0]     w_ptr_next;
  logic [SIZE-1:0]      w_chan [NUM];

  generate
    for (genvar k = 0; k < NUM; k++) begin : g_unpack
      assign w_chan[k] = data_i[k*SIZE +: SIZE];
    end
  endgenerate

  // The register refills in the same cycle it drains.
  assign w_load_en = !r_valid || ready_i;

  // Round-robin scan from r_ptr with wrap modulo NUM. Walking the offsets
  // downwards lets the nearest valid channel overwrite any farther one.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_pos      = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      w_pos = {1'b0, r_ptr} + (SEL_W+1)'(i);
      if (w_pos >= c_num) begin
        w_pos = w_pos - c_num;
      end
      if (valid_i[w_pos[SEL_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_pos[SEL_W-1:0];
      end
    end
  end

  assign w_fx_ok    = ({1'b0, select_i} < c_num);
  assign w_has_cand = mode_i ? w_rr_found : w_fx_ok;
  assign w_cand     = mode_i ? w_rr_idx   : select_i;

  always_comb begin
    w_cand_valid = 1'b0;
    w_cand_data  = '0;
    w_ready      = '0;
    for (int k = 0; k < NUM; k++) begin
      if (SEL_W'(k) == w_cand) begin
        w_cand_valid = valid_i[k];
        w_cand_data  = w_chan[k];
        w_ready[k]   = w_has_cand && w_load_en;
      end
    end
  end

  assign ready_o  = w_ready;
  assign w_accept = w_has_cand && w_load_en && w_cand_valid;

  assign w_cand_inc = {1'b0, w_cand} + (SEL_W+1)'(1);
  assign w_ptr_next = (w_cand_inc >= c_num) ? '0 : w_cand_inc[SEL_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= w_cand_data;
        r_grant <= w_cand;
        if (mode_i) begin
          r_ptr <= w_ptr_next;
        end
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign grant_o = r_grant;

endmodule

`default_nettype wire
